// File: rtl/gol_generation_sequencer.sv
// Generation sequencer for the Game of Life engine.
// Runs a requested number of generations back to back. Between generations it
// swaps the source and destination frame buffers. It reports progress, the
// final frame address and timeout/abort errors to the HPS PIOs. It also owns
// the engine's active-high reset.
module gol_generation_sequencer #(
  parameter int ADDR_W         = 12,
  parameter int GEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RESET_CYCLES   = 4
) (
  input  logic              fpga_clk_50,
  input  logic              hps_fpga_reset_n,
  input  logic              host_go,
  input  logic              host_abort,
  input  logic [GEN_W-1:0]  host_generations,
  input  logic [ADDR_W-1:0] host_buf_a,
  input  logic [ADDR_W-1:0] host_buf_b,
  output logic              host_busy,
  output logic              host_done,
  output logic              host_error,
  output logic [GEN_W-1:0]  host_gen_count,
  output logic [ADDR_W-1:0] host_final_address,
  output logic [ADDR_W-1:0] eng_starting_address,
  output logic [ADDR_W-1:0] eng_result_address,
  output logic              eng_initialize,
  output logic              eng_reset,
  input  logic              eng_started,
  input  logic              eng_completed
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RC_W  = $clog2(RESET_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    RST_HOLD, IDLE, ISSUE, WAIT_START, RUN, GAP, FAULT
  } state_t;

  state_t state, state_d;

  logic              go_q;
  logic              go_edge;
  logic [RC_W-1:0]   rst_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  logic [GEN_W-1:0]  gens;
  logic [GEN_W-1:0]  gen_count;
  logic [GEN_W-1:0]  gen_count_inc;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] final_addr;
  logic              busy;
  logic              done;
  logic              error;
  logic              gen_step;

  assign go_edge       = host_go & ~go_q;
  assign tmo_hit       = (tmo_cnt == TMO_LAST);
  assign gen_count_inc = gen_count + 1'b1;
  // Abort outranks completion; completion outranks a coincident timeout.
  assign gen_step      = (state == RUN) && eng_completed && !host_abort;

  assign host_busy            = busy;
  assign host_done            = done;
  assign host_error           = error;
  assign host_gen_count       = gen_count;
  assign host_final_address   = final_addr;
  assign eng_starting_address = src;
  assign eng_result_address   = dst;
  assign eng_initialize       = (state == ISSUE) || (state == WAIT_START);
  assign eng_reset            = (state == RST_HOLD);

  // Next-state selection: abort first, then the exit condition, then timeout.
  always_comb begin
    state_d = state;
    unique case (state)
      RST_HOLD:   if (rst_cnt == RC_LAST) state_d = IDLE;
      IDLE:       if (go_edge && (host_generations != '0)) state_d = ISSUE;
      ISSUE:      state_d = host_abort ? FAULT : WAIT_START;
      WAIT_START: begin
        if (host_abort)                        state_d = FAULT;
        else if (eng_started && !eng_completed) state_d = RUN;
        else if (tmo_hit)                      state_d = FAULT;
      end
      RUN: begin
        if (host_abort)                           state_d = FAULT;
        else if (eng_completed)                   state_d = (gen_count_inc == gens) ? IDLE : GAP;
        else if (tmo_hit)                         state_d = FAULT;
      end
      GAP:        state_d = host_abort ? FAULT : ISSUE;
      FAULT:      state_d = RST_HOLD;
      default:    state_d = RST_HOLD;
    endcase
  end

  // State register, reset-hold and timeout counters, go edge history.
  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      state   <= RST_HOLD;
      rst_cnt <= '0;
      tmo_cnt <= '0;
      go_q    <= 1'b0;
    end else begin
      state   <= state_d;
      rst_cnt <= (state == RST_HOLD) ? rst_cnt + 1'b1 : '0;
      // Restarts on every state change, so RUN gets its own full window.
      if (((state == WAIT_START) || (state == RUN)) && (state_d == state))
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
      // Frozen during the reset hold so a go held across power-on is still seen as an edge.
      if (state != RST_HOLD)
        go_q <= host_go;
    end
  end

  // Sequence bookkeeping: latch request, count generations, swap buffers, flag errors.
  always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
    if (!hps_fpga_reset_n) begin
      gens       <= '0;
      gen_count  <= '0;
      src        <= '0;
      dst        <= '0;
      final_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else if ((state == IDLE) && go_edge) begin
      gens       <= host_generations;
      gen_count  <= '0;
      src        <= host_buf_a;
      dst        <= host_buf_b;
      final_addr <= host_buf_a;
      busy       <= (host_generations != '0);
      done       <= (host_generations == '0);
      error      <= 1'b0;
    end else if (gen_step) begin
      gen_count  <= gen_count_inc;
      final_addr <= dst;
      src        <= dst;
      dst        <= src;
      if (gen_count_inc == gens) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else if (state_d == FAULT) begin
      busy  <= 1'b0;
      done  <= 1'b1;
      error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gol_generation_sequencer.sv
// Directed bench for gol_generation_sequencer with a small behavioural engine.
module tb_gol_generation_sequencer;

  localparam int ADDR_W = 12;
  localparam int GEN_W  = 16;

  logic              fpga_clk_50 = 1'b0;
  logic              hps_fpga_reset_n = 1'b0;
  logic              host_go = 1'b0;
  logic              host_abort = 1'b0;
  logic [GEN_W-1:0]  host_generations = '0;
  logic [ADDR_W-1:0] host_buf_a = '0;
  logic [ADDR_W-1:0] host_buf_b = '0;
  logic              host_busy;
  logic              host_done;
  logic              host_error;
  logic [GEN_W-1:0]  host_gen_count;
  logic [ADDR_W-1:0] host_final_address;
  logic [ADDR_W-1:0] eng_starting_address;
  logic [ADDR_W-1:0] eng_result_address;
  logic              eng_initialize;
  logic              eng_reset;
  logic              eng_started = 1'b0;
  logic              eng_completed = 1'b0;

  gol_generation_sequencer #(
    .ADDR_W(ADDR_W), .GEN_W(GEN_W), .TIMEOUT_CYCLES(16), .RESET_CYCLES(4)
  ) dut (
    .fpga_clk_50(fpga_clk_50),
    .hps_fpga_reset_n(hps_fpga_reset_n),
    .host_go(host_go),
    .host_abort(host_abort),
    .host_generations(host_generations),
    .host_buf_a(host_buf_a),
    .host_buf_b(host_buf_b),
    .host_busy(host_busy),
    .host_done(host_done),
    .host_error(host_error),
    .host_gen_count(host_gen_count),
    .host_final_address(host_final_address),
    .eng_starting_address(eng_starting_address),
    .eng_result_address(eng_result_address),
    .eng_initialize(eng_initialize),
    .eng_reset(eng_reset),
    .eng_started(eng_started),
    .eng_completed(eng_completed)
  );

  always #10 fpga_clk_50 = ~fpga_clk_50;

  // Engine model and monitor state (written only by the negedge process).
  int          eng_cnt = 0;
  logic        eng_active = 1'b0;
  logic        init_q = 1'b0;
  int          init_rises = 0;
  int          low_run = 0;
  int          min_low = 1000;
  int          done_total = 0;
  logic [11:0] src_log [0:63];
  logic [11:0] dst_log [0:63];
  logic [15:0] cnt_log [0:63];
  // Controls written only by the main process.
  logic        eng_hang = 1'b0;
  int          abort_at = -1;

  // Engine: started 2 cycles after an initialize rise, completed after 10.
  always @(negedge fpga_clk_50) begin
    host_abort = 1'b0;
    if (eng_reset) begin
      eng_started = 1'b0; eng_completed = 1'b0; eng_active = 1'b0; eng_cnt = 0;
    end else if (eng_initialize && !init_q) begin
      eng_active = 1'b1; eng_cnt = 0; eng_completed = 1'b0; eng_started = 1'b0;
    end else if (eng_active) begin
      eng_cnt++;
      if (eng_cnt == 2) eng_started = 1'b1;
      if (eng_cnt == 10 && !eng_hang) begin
        eng_completed = 1'b1; eng_started = 1'b0; eng_active = 1'b0;
        done_total++;
        if (done_total == abort_at) host_abort = 1'b1;
      end
    end
    if (eng_initialize && !init_q) begin
      if (init_rises < 64) begin
        src_log[init_rises] = eng_starting_address;
        dst_log[init_rises] = eng_result_address;
        cnt_log[init_rises] = host_gen_count;
      end
      if (init_rises > 0 && low_run < min_low) min_low = low_run;
      init_rises++;
    end
    low_run = eng_initialize ? 0 : low_run + 1;
    init_q  = eng_initialize;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge fpga_clk_50); #1; end
  endtask

  task automatic start_run(input int g, input logic [11:0] a, input logic [11:0] b);
    host_generations = 16'(g); host_buf_a = a; host_buf_b = b;
    host_go = 1'b1;
    @(posedge fpga_clk_50); #1;
    host_go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!host_done && n < 1000) begin @(posedge fpga_clk_50); #1; n++; end
    chk({tag, "_done"}, 32'(host_done), 32'd1);
  endtask

  // Cycles eng_reset stays high, measured from the first cycle it is seen high.
  task automatic reset_hold_len(output int n);
    int w = 0;
    while (!eng_reset && w < 50) begin @(posedge fpga_clk_50); #1; w++; end
    n = 0;
    while (eng_reset && n < 50) begin @(posedge fpga_clk_50); #1; n++; end
  endtask

  initial begin
    int n;
    int base;
    // Power-on reset
    cycles(2);
    chk("rst_eng_reset", 32'(eng_reset), 1);
    chk("rst_outputs", {host_busy, host_done, host_error, eng_initialize}, 0);
    chk("rst_addr", {eng_starting_address, eng_result_address, host_final_address}, 0);
    hps_fpga_reset_n = 1'b1;
    reset_hold_len(n);
    chk("por_hold_len", n, 4);
    cycles(20);
    chk("idle_no_init", init_rises, 0);
    chk("idle_host", {host_busy, host_done, host_error, host_gen_count, host_final_address}, 0);

    // Three generations with buffer ping-pong
    base = init_rises;
    start_run(3, 12'h000, 12'h400);
    chk("g3_busy", 32'(host_busy), 1);
    wait_done("g3");
    chk("g3_issues", init_rises - base, 3);
    chk("g3_pair0", {src_log[base],   dst_log[base]},   {12'h000, 12'h400});
    chk("g3_pair1", {src_log[base+1], dst_log[base+1]}, {12'h400, 12'h000});
    chk("g3_pair2", {src_log[base+2], dst_log[base+2]}, {12'h000, 12'h400});
    chk("g3_cnt_seq", {cnt_log[base], cnt_log[base+1], cnt_log[base+2]}, {16'd0, 16'd1, 16'd2});
    chk("g3_count", host_gen_count, 3);
    chk("g3_final", host_final_address, 12'h400);
    chk("g3_flags", {host_busy, host_error}, 0);
    chk("g3_init_gap", 32'(min_low >= 1), 1);

    // Zero generations: done immediately, nothing issued
    cycles(3);
    base = init_rises;
    start_run(0, 12'h123, 12'h456);
    chk("g0_done", 32'(host_done), 1);
    chk("g0_final", host_final_address, 12'h123);
    chk("g0_count", host_gen_count, 0);
    chk("g0_busy", 32'(host_busy), 0);
    cycles(10);
    chk("g0_no_init", init_rises - base, 0);

    // Timeout: engine acknowledges but never completes
    eng_hang = 1'b1;
    start_run(2, 12'h000, 12'h400);
    n = 0;
    while (eng_initialize && n < 100) begin @(posedge fpga_clk_50); #1; n++; end
    n = 0;
    while (!host_error && n < 100) begin @(posedge fpga_clk_50); #1; n++; end
    chk("tmo_latency", n, 16);
    chk("tmo_flags", {host_error, host_done, host_busy}, 3'b110);
    chk("tmo_count", host_gen_count, 0);
    reset_hold_len(n);
    chk("tmo_hold_len", n, 4);
    eng_hang = 1'b0;

    // Abort coincident with the second completion
    cycles(2);
    abort_at = done_total + 2;
    start_run(5, 12'h000, 12'h400);
    wait_done("abt");
    chk("abt_count", host_gen_count, 1);
    chk("abt_error", 32'(host_error), 1);
    chk("abt_final", host_final_address, 12'h400);
    reset_hold_len(n);
    chk("abt_hold_len", n, 4);
    abort_at = -1;
    cycles(2);
    start_run(2, 12'h000, 12'h400);
    chk("rerun_cleared", {host_done, host_error, host_gen_count}, 0);
    wait_done("rerun");
    chk("rerun_count", host_gen_count, 2);
    chk("rerun_final", {host_final_address, host_error}, {12'h000, 1'b0});

    // Asynchronous reset in the middle of a run
    cycles(2);
    base = init_rises;
    start_run(3, 12'h010, 12'h400);
    n = 0;
    while (init_rises < base + 2 && n < 200) begin @(posedge fpga_clk_50); #1; n++; end
    n = 0;
    while (eng_initialize && n < 100) begin @(posedge fpga_clk_50); #1; n++; end
    cycles(3);
    chk("mid_pre_count", host_gen_count, 1);
    hps_fpga_reset_n = 1'b0;
    #1;
    chk("mid_eng_reset", 32'(eng_reset), 1);
    chk("mid_flags", {host_busy, host_done, host_error, eng_initialize}, 0);
    chk("mid_values", {host_gen_count, host_final_address, eng_starting_address, eng_result_address}, 0);
    cycles(2);
    hps_fpga_reset_n = 1'b1;
    reset_hold_len(n);
    chk("mid_hold_len", n, 4);
    base = init_rises;
    cycles(20);
    chk("mid_waits_go", {init_rises - base, 31'(host_busy)}, 0);
    start_run(1, 12'h020, 12'h030);
    wait_done("post");
    chk("post_result", {host_gen_count, host_final_address, host_error}, {16'd1, 12'h030, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gol_generation_sequencer.md
Name: gol_generation_sequencer

Overview:
- Sits between the HPS-facing PIO registers and the Game of Life engine.
- Runs N consecutive generations without HPS intervention. For each generation it drives the engine's start/result addresses and initialize trigger, waits for completion, then ping-pongs the two frame buffers in on-chip memory.
- Reports progress, the final frame address, and timeout/abort errors back to the HPS PIOs.
- Owns the engine's active-high reset.

Parameters:
- ADDR_W, 12, width of on-chip memory frame addresses
- GEN_W, 16, width of generation count
- TIMEOUT_CYCLES, 1000000, maximum cycles allowed in WAIT_START or RUN before error (must be >= 2)
- RESET_CYCLES, 4, cycles eng_reset is held high after power-on reset release, abort or timeout (must be >= 1)

Ports:
- fpga_clk_50  in  1  system clock
- hps_fpga_reset_n  in  1  asynchronous active-low reset
- host_go  in  1  start request from PIO (level; rising edge accepted)
- host_abort  in  1  abort request from PIO (level; sampled every cycle)
- host_generations  in  GEN_W  number of generations to run
- host_buf_a  in  ADDR_W  base address of initial frame
- host_buf_b  in  ADDR_W  base address of scratch frame
- host_busy  out  1  sequence in progress
- host_done  out  1  sticky: sequence ended (success or error)
- host_error  out  1  sticky: sequence ended by timeout or abort
- host_gen_count  out  GEN_W  generations completed in current/last sequence
- host_final_address  out  ADDR_W  base address holding latest completed frame
- eng_starting_address  out  ADDR_W  source frame for engine
- eng_result_address  out  ADDR_W  destination frame for engine
- eng_initialize  out  1  engine trigger, level
- eng_reset  out  1  engine reset, active high
- eng_started  in  1  engine acknowledges initialize
- eng_completed  in  1  engine finished generation (level, cleared by engine on next initialize)

Behaviour:
- Reset is asynchronous, active-low. While asserted:
  - state = RST_HOLD; eng_reset = 1.
  - All other outputs are 0; address outputs and host_final_address are 0.
- Clock is fpga_clk_50 only.
- States: RST_HOLD, IDLE, ISSUE, WAIT_START, RUN, GAP, FAULT.
- RST_HOLD: eng_reset = 1 for RESET_CYCLES cycles after entry (counting from reset release), then go to IDLE with eng_reset = 0.
- go_edge = host_go & ~host_go_q. host_go_q is registered and resets to 0, so a go held across reset release is accepted.
- IDLE, on go_edge:
  - Latch gens, src = host_buf_a, dst = host_buf_b.
  - Clear host_done, host_error and host_gen_count; set host_final_address = host_buf_a.
  - If gens == 0: set host_done = 1 next cycle, stay IDLE, host_busy stays 0.
  - Otherwise: host_busy = 1, go to ISSUE.
  - go_edge outside IDLE is ignored.
- ISSUE (1 cycle):
  - eng_starting_address = src, eng_result_address = dst; both stable from ISSUE until leaving RUN.
  - Assert eng_initialize, clear the timeout counter, go to WAIT_START.
- WAIT_START: eng_initialize held 1 until eng_started == 1 && eng_completed == 0 is sampled; then drop eng_initialize and go to RUN.
- RUN: on eng_completed == 1:
  - host_gen_count += 1; host_final_address = dst; swap src/dst.
  - If new count == gens: host_busy = 0, host_done = 1, go to IDLE.
  - Else go to GAP.
- GAP (1 cycle): eng_initialize = 0, so the engine always sees a fresh rising edge. Then go to ISSUE.
- Timeout:
  - The counter increments each cycle in WAIT_START and RUN.
  - When it reaches TIMEOUT_CYCLES-1 without the exit condition, go to FAULT.
  - If the exit condition and the timeout occur in the same cycle, the exit condition wins.
- Abort:
  - host_abort == 1 in ISSUE/WAIT_START/RUN/GAP goes to FAULT; abort has priority over completion in the same cycle.
  - host_abort in IDLE/RST_HOLD has no effect.
- FAULT (1 cycle):
  - eng_initialize = 0; host_error = 1, host_done = 1, host_busy = 0.
  - host_gen_count and host_final_address keep the last successful values.
  - Go to RST_HOLD (eng_reset = 1 for RESET_CYCLES).
- Arithmetic: host_gen_count wraps never, because count ≤ gens ≤ 2^GEN_W − 1. The timeout counter is wide enough for TIMEOUT_CYCLES.

Test Plan:
- Reset release, no go -> eng_reset = 1 for exactly 4 cycles then 0; all host outputs 0; eng_initialize never asserts.
- gens = 3, buf_a = 0x000, buf_b = 0x400, engine model acks started after 2 cycles and completed after 10:
  - address pairs (0x000→0x400), (0x400→0x000), (0x000→0x400);
  - host_gen_count 1, 2, 3;
  - host_final_address = 0x400;
  - host_done = 1, host_error = 0, host_busy = 0;
  - eng_initialize low ≥ 1 cycle between generations.
- gens = 0 with go -> host_done = 1 one cycle later, host_final_address = host_buf_a, no eng_initialize pulse.
- TIMEOUT_CYCLES = 16, engine never raises completed -> FAULT entered 16 cycles after entering RUN; host_error = 1; eng_reset high 4 cycles; count unchanged.
- gens = 5, host_abort raised in the same cycle as the 2nd eng_completed:
  - host_gen_count = 1, host_error = 1;
  - eng_reset pulses; subsequent go runs normally from count 0.
- hps_fpga_reset_n asserted mid-RUN -> outputs immediately 0 except eng_reset = 1; after release, 4-cycle reset hold, then IDLE awaits a new go edge.
